hps_to_fpga_pio_fifo: RTL and testbench
=======================================

// Module: hps_to_fpga_pio_fifo
// PURPOSE
//   Avalon-MM slave PIO for the HPS-to-FPGA direction. It is the counterpart of the
//   from-FPGA input PIO.
//   HPS writes 32-bit words into a small FIFO. Fabric logic drains the words over a
//   valid/ready stream, which carries LB solver commands and parameters.
//   Status and control registers let software poll the fill level, detect dropped
//   writes and flush the FIFO.
// PARAMETERS
//   DATA_W   32  width of writedata, readdata and out_data
//   DEPTH     4  FIFO entries; must be a power of 2, >= 2
//   LVL_W    clog2(DEPTH)+1  width of the fill-level field (derived; do not override)
// PORTS
//   clk        in   1       system clock
//   reset_n    in   1       asynchronous active-low reset
//   address    in   2       Avalon word address
//   chipselect in   1       Avalon select
//   write_n    in   1       Avalon write strobe, active-low (qualified by chipselect)
//   read       in   1       Avalon read strobe (qualified by chipselect)
//   writedata  in   DATA_W  Avalon write data
//   readdata   out  DATA_W  Avalon read data, registered
//   out_data   out  DATA_W  FIFO head word toward fabric
//   out_valid  out  1       head word valid (FIFO not empty)
//   out_ready  in   1       fabric accepts head word this cycle
// BEHAVIOUR
//   Reset (async, reset_n=0)
//     - FIFO empty; rd/wr pointers = 0; overflow = 0; shadow = 0.
//     - readdata = 0; out_valid = 0; out_data = 0.
//   Register map (wr = chipselect & ~write_n; rd = chipselect & read)
//     0 DATA
//       - wr: push writedata, shadow <= writedata.
//       - rd: shadow, i.e. the last word written, whether accepted or dropped.
//     1 STATUS (rd)
//       - [LVL_W-1:0] level; [16] empty; [17] full; [18] overflow; other bits 0.
//       - wr ignored.
//     2 CONTROL (wr)
//       - bit0=1 clears overflow; bit1=1 flushes the FIFO; both may be set together.
//       - rd returns 0.
//     3 reserved: rd returns 0; wr ignored.
//   Read timing
//     - readdata updates on the clock edge after rd is sampled: 1-cycle latency.
//     - readdata holds its value when no read occurs.
//     - STATUS reflects the state before that edge's push/pop.
//   Stream side
//     - out_valid = ~empty; out_data = mem[rd_ptr] (combinational from registered state).
//     - Pop occurs when out_valid & out_ready; rd_ptr advances and wraps mod DEPTH.
//     - out_data must hold stable while out_valid=1 and out_ready=0.
//   Push
//     - A wr to DATA writes mem[wr_ptr]; wr_ptr advances and wraps mod DEPTH.
//   Boundary rules
//     - Push while full, no pop: word dropped; overflow <= 1 (sticky); level stays DEPTH.
//     - Push and pop same cycle while full: push accepted; level unchanged; no overflow.
//     - Push and pop same cycle while not empty: level unchanged.
//     - Push while empty: out_valid rises the next cycle; no write-through bypass.
//     - Flush: pointers and level reset to 0; a concurrent pop is ignored.
//       Flush does not clear overflow unless bit0 is also set.
//     - Overflow set and clear in the same cycle cannot occur: they need separate
//       addresses.
//     - Level counter width LVL_W represents 0..DEPTH inclusive.
//     - Async reset mid-transfer discards FIFO contents; out_valid drops immediately.
// TESTING
//   1 Reset, then rd STATUS
//       -> readdata = 0x0001_0000 (empty=1, level 0); out_valid = 0.
//   2 wr DATA 0xA5A5_0001, out_ready=0
//       -> next cycle out_valid=1, out_data=0xA5A5_0001.
//       -> STATUS level=1; rd DATA returns 0xA5A5_0001.
//   3 Push 5 words (1..5) with DEPTH=4, out_ready=0
//       -> STATUS = 0x0006_0004 (full=1, overflow=1, level 4).
//       -> Drain yields 1,2,3,4; then out_valid=0.
//   4 Fill to full; assert out_ready together with wr DATA 0x99
//       -> no overflow; level stays 4.
//       -> Drain order is the remaining 3 words, then 0x99. Exercises pointer wrap.
//   5 Level 3, then wr CONTROL 0x2 in the same cycle as a pop
//       -> level 0, out_valid=0, overflow unchanged.
//       -> Then wr CONTROL 0x1 -> overflow=0.
//   6 Deassert reset_n mid-drain, asynchronously to clk
//       -> out_valid and readdata go to 0 without waiting for a clock edge.
//       -> After release, STATUS shows empty.

Source files
------------

// File: rtl/hps_to_fpga_pio_fifo_if.sv
// Bus bundle for the HPS-to-FPGA PIO FIFO.
//   Avalon-MM side : address, chipselect, write_n, read, writedata, readdata
//   Stream side    : out_data, out_valid, out_ready
// slave modport is the PIO itself; master modport is the HPS/fabric side.
interface hps_to_fpga_pio_fifo_if #(
  parameter int unsigned DATA_W = 32
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic              read;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  address, chipselect, write_n, read, writedata, out_ready,
    output readdata, out_data, out_valid
  );

  modport master (
    output address, chipselect, write_n, read, writedata, out_ready,
    input  readdata, out_data, out_valid
  );
endinterface

// File: rtl/hps_to_fpga_pio_fifo.sv
// HPS-to-FPGA PIO: Avalon-MM writes fill a small FIFO that fabric drains over
// a valid/ready stream. Registers: 0 DATA (wr push / rd last written word),
// 1 STATUS (level, empty, full, overflow), 2 CONTROL (bit0 clear overflow,
// bit1 flush), 3 reserved.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave modport carrying the Avalon and stream signals
module hps_to_fpga_pio_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  hps_to_fpga_pio_fifo_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              wr_c, rd_c, full_c, empty_c, pop_c;
  logic              push_req_c, push_ok_c, flush_c, clr_ovf_c;
  logic [DATA_W-1:0] status_c;

  // Bus decode and FIFO handshake qualifiers
  always_comb begin
    wr_c       = bus.chipselect & ~bus.write_n;
    rd_c       = bus.chipselect & bus.read;
    full_c     = (level_q == LVL_W'(DEPTH));
    empty_c    = (level_q == '0);
    pop_c      = ~empty_c & bus.out_ready;
    push_req_c = wr_c & (bus.address == ADDR_DATA);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push_ok_c  = push_req_c & (~full_c | pop_c);
    flush_c    = wr_c & (bus.address == ADDR_CTRL) & bus.writedata[1];
    clr_ovf_c  = wr_c & (bus.address == ADDR_CTRL) & bus.writedata[0];
  end

  // STATUS word, built from pre-edge state
  always_comb begin
    status_c              = '0;
    status_c[LVL_W-1:0]   = level_q;
    status_c[16]          = empty_c;
    status_c[17]          = full_c;
    status_c[18]          = ovf_q;
  end

  // Next-state for pointers, level, overflow, shadow and read data
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;

    if (push_req_c) shadow_d = bus.writedata;

    // Flush overrides any concurrent pop; push cannot coincide (other address)
    if (flush_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok_c, pop_c})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    if (push_req_c & full_c & ~pop_c) ovf_d = 1'b1;
    else if (clr_ovf_c)               ovf_d = 1'b0;

    if (rd_c) begin
      case (bus.address)
        ADDR_DATA:   rdata_d = shadow_q;
        ADDR_STATUS: rdata_d = status_c;
        default:     rdata_d = '0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      shadow_q <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      if (push_ok_c) mem_q[wr_ptr_q] <= bus.writedata;
    end
  end

  // Stream head is read straight from registered storage
  assign bus.out_valid = ~empty_c;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.readdata  = rdata_q;

endmodule

// File: tb/tb_hps_to_fpga_pio_fifo.sv
module tb_hps_to_fpga_pio_fifo;
  logic clk;
  logic reset_n;

  hps_to_fpga_pio_fifo_if #(.DATA_W(32)) bus ();

  hps_to_fpga_pio_fifo #(.DATA_W(32), .DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [31:0] rd_q [$];
  logic [31:0] st_q [$];
  logic        pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input bit accepted);
    if (accepted) st_q.push_back(d);
    wr(2'd0, d);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16 && bus.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_done", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  // Monitor: compares read responses and stream pops against the queues
  initial begin : monitor
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (rd_q.size() == 0) begin
          n_total++;
          $display("FAIL readdata: unexpected response %h", bus.readdata);
        end else chk("readdata", bus.readdata, rd_q.pop_front());
      end
      pend = bus.chipselect & bus.read & reset_n;
      if (reset_n && bus.out_valid && bus.out_ready) begin
        if (st_q.size() == 0) begin
          n_total++;
          $display("FAIL stream: unexpected word %h", bus.out_data);
        end else chk("out_data", bus.out_data, st_q.pop_front());
      end
    end
  end

  initial begin : stim
    reset_n        = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read       = 1'b0;
    bus.address    = 2'd0;
    bus.writedata  = '0;
    bus.out_ready  = 1'b0;
    #22 reset_n = 1'b1;
    idle(1);

    // 1: reset state
    chk("rst_readdata",  bus.readdata, 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data, 32'h0);
    rd(2'd1, 32'h0001_0000);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);
    idle(1);

    // 2: single push, no bypass
    push(32'hA5A5_0001, 1'b1);
    chk("t2_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_data",  bus.out_data, 32'hA5A5_0001);
    rd(2'd1, 32'h0000_0001);
    rd(2'd0, 32'hA5A5_0001);
    idle(1);
    drain();

    // 3: overflow on 5th push; shadow keeps dropped word
    for (int i = 1; i <= 5; i++) push(32'(i), i <= 4);
    rd(2'd1, 32'h0006_0004);
    rd(2'd0, 32'h0000_0005);
    idle(1);
    drain();
    wr(2'd2, 32'h1);
    rd(2'd1, 32'h0001_0000);
    idle(1);

    // 4: push+pop while full, pointer wrap
    push(32'h11, 1'b1);
    push(32'h22, 1'b1);
    push(32'h33, 1'b1);
    push(32'h44, 1'b1);
    bus.out_ready = 1'b1;
    push(32'h99, 1'b1);
    bus.out_ready = 1'b0;
    rd(2'd1, 32'h0002_0004);
    idle(1);
    drain();

    // 5: flush with concurrent pop keeps overflow; then clear it
    for (int i = 1; i <= 5; i++) push(32'h50 + 32'(i), i <= 4);
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0004_0003);
    idle(1);
    bus.out_ready = 1'b1;
    wr(2'd2, 32'h2);
    bus.out_ready = 1'b0;
    st_q.delete();
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    rd(2'd1, 32'h0005_0000);
    wr(2'd2, 32'h1);
    rd(2'd1, 32'h0001_0000);
    idle(1);

    // 6: async reset mid-drain
    push(32'h61, 1'b1);
    push(32'h62, 1'b1);
    push(32'h63, 1'b1);
    rd(2'd0, 32'h63);
    idle(1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    st_q.delete();
    bus.out_ready = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_readdata", bus.readdata, 32'h0);
    chk("t6_out_data", bus.out_data, 32'h0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;
    rd(2'd1, 32'h0001_0000);
    idle(2);

    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("st_q_empty", 32'(st_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1);
  end
endmodule
